axi_slave_mem: RTL and testbench

- Parametrised AXI4 slave memory model: the next-generation RTL responder for the AXI master clocking interface used on the LPDDR bench.
- Accepts one write burst and one read burst concurrently.
- Supports FIXED, INCR and WRAP bursts, byte strobes, narrow transfers and ID echo.
- Backs all accesses with an internal word array; stands in for the LPDDR controller during AXI-layer bring-up.

---
 rtl/axi_slave_mem_pkg.sv | 46 ++++
 rtl/axi_slave_mem_if.sv | 79 +++++++
 rtl/axi_burst_addr_gen.sv | 54 +++++
 rtl/axi_slave_mem.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slave_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared types and constants for the AXI4 slave memory model:
//   - AXI field widths (len/size/burst/resp)
//   - burst_e / resp_e encodings
//   - write and read FSM state enums
//   - wrap_len_ok(): legal WRAP burst lengths
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  // 2'b11 is the reserved burst encoding and is treated as illegal.
  typedef enum logic [BURST_W-1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// -----------------------------------------------------------------------------
// axi_slave_mem_if
// AXI4 bus bundle (AW, W, B, AR, R channels) between a master and the
// axi_slave_mem responder. Clock and reset are not part of the bundle.
//   modport slave  : used by axi_slave_mem
//   modport master : used by the driving side (bench or bus fabric)
// Parameters: ID_W, ADDR_W, DATA_W (STRB_W derived as DATA_W/8).
// -----------------------------------------------------------------------------
interface axi_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  import axi_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  // Write address
  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awvalid;
  logic               awready;
  // Write data
  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  // Write response
  logic [ID_W-1:0]    bid;
  logic [RESP_W-1:0]  bresp;
  logic               bvalid;
  logic               bready;
  // Read address
  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arvalid;
  logic               arready;
  // Read data
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational AXI4 beat-address stepper and burst legality check.
//   addr/len/size/burst : current beat address and burst descriptor
//   next_addr           : address of the following beat (FIXED/INCR/WRAP)
//   legal               : size fits the bus, burst encoding valid, WRAP length valid
//   oob                 : word index of addr is >= DEPTH (only when
//                         AXI_SLV_DECERR_EN is defined, else tied 0)
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BOFS   = 3,
  parameter int DEPTH  = 4096
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               legal,
  output logic               oob
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    step      = ADDR_W'(1) << size;
    // Window is (len+1) beats of 2^size bytes, aligned to its own size.
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr_addr = addr + step;
    next_addr = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase
    legal = (int'(size) <= BOFS) &&
            (burst != 2'b11) &&
            ((burst != WRAP) || wrap_len_ok(len));
  end

`ifdef AXI_SLV_DECERR_EN
  assign oob = (addr >> BOFS) >= ADDR_W'(DEPTH);
`else
  assign oob = 1'b0;
`endif

endmodule

// File: rtl/axi_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_slave_mem
// AXI4 slave memory model: one write burst and one read burst in flight at
// once, FIXED/INCR/WRAP bursts, byte strobes, narrow transfers, ID echo.
// Backed by a DEPTH x DATA_W word array indexed by (addr >> BOFS) mod DEPTH.
//   aclk    : clock
//   aresetn : synchronous active-low reset (array contents survive reset)
//   axi     : AXI4 slave bundle (axi_slave_mem_if.slave)
// Optional: define AXI_SLV_DECERR_EN to answer bursts whose start word index
// is >= DEPTH with DECERR (writes suppressed, rdata=0) instead of aliasing.
// -----------------------------------------------------------------------------
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_slave_mem_if.slave   axi
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BOFS   = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              mem_we;
  logic              mem_re;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_e           w_state;
  logic [ID_W-1:0]    w_id;
  logic [ADDR_W-1:0]  w_addr;
  logic [LEN_W-1:0]   w_len;
  logic [SIZE_W-1:0]  w_size;
  logic [BURST_W-1:0] w_burst;
  logic [LEN_W-1:0]   w_cnt;
  logic               w_legal;
  logic               w_oob;
  logic               awready_q;
  logic               wready_q;
  logic               bvalid_q;
  logic [ID_W-1:0]    bid_q;
  logic [RESP_W-1:0]  bresp_q;

  logic [ADDR_W-1:0]  wg_addr;
  logic [LEN_W-1:0]   wg_len;
  logic [SIZE_W-1:0]  wg_size;
  logic [BURST_W-1:0] wg_burst;
  logic [ADDR_W-1:0]  wg_next;
  logic               wg_legal;
  logic               wg_oob;

  logic               w_hs;
  logic               w_last_pos;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_e           r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [SIZE_W-1:0]  r_size;
  logic [BURST_W-1:0] r_burst;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_ok;
  logic               arready_q;
  logic               rvalid_q;
  logic               rlast_q;
  logic [ID_W-1:0]    rid_q;
  logic [RESP_W-1:0]  rresp_q;

  logic [ADDR_W-1:0]  rg_addr;
  logic [LEN_W-1:0]   rg_len;
  logic [SIZE_W-1:0]  rg_size;
  logic [BURST_W-1:0] rg_burst;
  logic [ADDR_W-1:0]  rg_next;
  logic               rg_legal;
  logic               rg_oob;

  logic               ar_hs;
  logic               r_hs;

  // ---------------------------------------------------------------------------
  // Address generators. While idle they look at the incoming AW/AR request so
  // legality and decode of the start address are known at handshake time;
  // during a burst they step the latched beat address.
  // ---------------------------------------------------------------------------
  always_comb begin
    wg_addr  = w_addr;
    wg_len   = w_len;
    wg_size  = w_size;
    wg_burst = w_burst;
    if (w_state == W_IDLE) begin
      wg_addr  = axi.awaddr;
      wg_len   = axi.awlen;
      wg_size  = axi.awsize;
      wg_burst = axi.awburst;
    end
  end

  always_comb begin
    rg_addr  = r_addr;
    rg_len   = r_len;
    rg_size  = r_size;
    rg_burst = r_burst;
    if (r_state == R_IDLE) begin
      rg_addr  = axi.araddr;
      rg_len   = axi.arlen;
      rg_size  = axi.arsize;
      rg_burst = axi.arburst;
    end
  end

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .BOFS   (BOFS),
    .DEPTH  (DEPTH)
  ) u_wr_gen (
    .addr      (wg_addr),
    .len       (wg_len),
    .size      (wg_size),
    .burst     (wg_burst),
    .next_addr (wg_next),
    .legal     (wg_legal),
    .oob       (wg_oob)
  );

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .BOFS   (BOFS),
    .DEPTH  (DEPTH)
  ) u_rd_gen (
    .addr      (rg_addr),
    .len       (rg_len),
    .size      (rg_size),
    .burst     (rg_burst),
    .next_addr (rg_next),
    .legal     (rg_legal),
    .oob       (rg_oob)
  );

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  assign w_hs       = (w_state == W_DATA) && axi.wvalid && wready_q;
  assign w_last_pos = (w_cnt == w_len);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_legal   <= 1'b0;
      w_oob     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi.awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id      <= axi.awid;
            w_addr    <= axi.awaddr;
            w_len     <= axi.awlen;
            w_size    <= axi.awsize;
            w_burst   <= axi.awburst;
            w_cnt     <= '0;
            w_legal   <= wg_legal;
            w_oob     <= wg_oob;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // The burst ends on the len-th beat or on wlast, whichever is first;
            // any disagreement between the two is a protocol error.
            if (w_last_pos || axi.wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_id;
              if (w_oob)
                bresp_q <= DECERR;
              else if (!w_legal || (axi.wlast != w_last_pos))
                bresp_q <= SLVERR;
              else
                bresp_q <= OKAY;
              w_state  <= W_RESP;
            end else begin
              w_addr <= wg_next;
              w_cnt  <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. rd_q is loaded with the next beat on the same edge that retires
  // the current one, giving back-to-back beats with one-cycle read latency.
  // ---------------------------------------------------------------------------
  assign ar_hs = (r_state == R_IDLE) && axi.arvalid && arready_q;
  assign r_hs  = (r_state == R_DATA) && rvalid_q && axi.rready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_ok      <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= axi.arid;
            rlast_q   <= (axi.arlen == 8'd0);
            r_addr    <= axi.araddr;
            r_len     <= axi.arlen;
            r_size    <= axi.arsize;
            r_burst   <= axi.arburst;
            r_cnt     <= '0;
            r_ok      <= rg_legal && !rg_oob;
            if (rg_oob)
              rresp_q <= DECERR;
            else if (!rg_legal)
              rresp_q <= SLVERR;
            else
              rresp_q <= OKAY;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              r_ok      <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_addr  <= rg_next;
              r_cnt   <= r_cnt + 8'd1;
              rlast_q <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Array access
  // ---------------------------------------------------------------------------
  assign mem_we = aresetn && w_hs && w_legal && !w_oob;
  assign w_idx  = w_addr[BOFS +: IDX_W];
  assign mem_re = ar_hs || (r_hs && !rlast_q);
  assign r_idx  = (r_state == R_IDLE) ? axi.araddr[BOFS +: IDX_W]
                                      : rg_next[BOFS +: IDX_W];

  // NOTE: the array and its read register carry no reset so they map onto
  // RAM; data therefore persists across aresetn. A same-word read and write
  // on one edge returns the old word.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
    if (mem_re) rd_q <= mem[r_idx];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  // Error bursts and idle cycles present zero regardless of the RAM output.
  assign axi.rdata   = r_ok ? rd_q : '0;

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;
  import axi_pkg::*;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4096;

  logic aclk;
  logic aresetn;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] wd  [16];
  logic [7:0]  ws  [16];
  logic [63:0] erd [16];

  axi_slave_mem_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_slave_mem #(
    .ID_W   (ID_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           input int bhold, output logic [1:0] resp, output logic [3:0] bid_o);
    bit hs;
    axi.awid    = id;
    axi.awaddr  = addr;
    axi.awlen   = len;
    axi.awsize  = size;
    axi.awburst = burst;
    axi.awvalid = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      hs = axi.awready;
      tick();
    end
    axi.awvalid = 1'b0;
    check("aw_handshake", hs, 1'b1);
    for (int i = 0; i < nbeats; i++) begin
      axi.wvalid = 1'b1;
      axi.wdata  = wd[i];
      axi.wstrb  = ws[i];
      axi.wlast  = (i == nbeats - 1);
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
        hs = axi.wready;
        tick();
      end
      check($sformatf("w_handshake[%0d]", i), hs, 1'b1);
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      hs = axi.bvalid;
      if (!hs) tick();
    end
    check("b_arrive", hs, 1'b1);
    for (int k = 0; k < bhold; k++) begin
      check("b_hold_bvalid", axi.bvalid, 1'b1);
      check("b_hold_awready", axi.awready, 1'b0);
      tick();
    end
    resp  = axi.bresp;
    bid_o = axi.bid;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  // Expected beat data comes from erd[]; rpat is the rready pattern cycled
  // every 4 cycles (bit 0 first).
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [1:0] exp_resp, input logic [3:0] rpat);
    bit hs;
    int beat;
    int cyc;
    axi.arid    = id;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    axi.arvalid = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      hs = axi.arready;
      tick();
    end
    axi.arvalid = 1'b0;
    check("ar_handshake", hs, 1'b1);
    check("r_latency", axi.rvalid, 1'b1);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 200) begin
      axi.rready = rpat[cyc % 4];
      if (axi.rvalid) begin
        check($sformatf("rdata[%0d]", beat), axi.rdata, erd[beat]);
        check($sformatf("rresp[%0d]", beat), axi.rresp, exp_resp);
        check($sformatf("rid[%0d]", beat), axi.rid, id);
        if (axi.rready) begin
          check($sformatf("rlast[%0d]", beat), axi.rlast, beat == int'(len));
          beat++;
        end
      end
      tick();
      cyc++;
    end
    axi.rready = 1'b0;
    check("r_beats", beat, int'(len) + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic [3:0] bid_o;

    aresetn     = 1'b0;
    axi.awid    = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready  = 1'b0;
    axi.arid    = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_awready", axi.awready, 1'b0);
    check("rst_arready", axi.arready, 1'b0);
    check("rst_wready", axi.wready, 1'b0);
    check("rst_bvalid", axi.bvalid, 1'b0);
    check("rst_rvalid", axi.rvalid, 1'b0);
    check("rst_rdata", axi.rdata, 64'h0);
    aresetn = 1'b1;
    tick();
    check("post_rst_awready", axi.awready, 1'b1);
    check("post_rst_arready", axi.arready, 1'b1);

    // INCR write 0x100, 4 beats, with bready held off for 5 cycles
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    axi_write(4'd5, 32'h100, 8'd3, 3'd3, INCR, 4, 5, resp, bid_o);
    check("incr_bresp", resp, OKAY);
    check("incr_bid", bid_o, 4'd5);

    // INCR read back
    erd[0] = 64'h11; erd[1] = 64'h22; erd[2] = 64'h33; erd[3] = 64'h44;
    axi_read(4'd9, 32'h100, 8'd3, 3'd3, INCR, OKAY, 4'b1111);

    // WRAP read from 0x118: 0x118, 0x100, 0x108, 0x110
    erd[0] = 64'h44; erd[1] = 64'h11; erd[2] = 64'h22; erd[3] = 64'h33;
    axi_read(4'd2, 32'h118, 8'd3, 3'd3, WRAP, OKAY, 4'b1111);

    // WRAP with len=2 is illegal: 3 beats, SLVERR, zero data
    erd[0] = 64'h0; erd[1] = 64'h0; erd[2] = 64'h0;
    axi_read(4'd6, 32'h100, 8'd2, 3'd3, WRAP, SLVERR, 4'b1111);

    // Read backpressure: rready 1,0,0,1 repeating
    erd[0] = 64'h11; erd[1] = 64'h22; erd[2] = 64'h33; erd[3] = 64'h44;
    axi_read(4'd7, 32'h100, 8'd3, 3'd3, INCR, OKAY, 4'b1001);

    // Strobe merge
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    axi_write(4'd1, 32'h200, 8'd0, 3'd3, INCR, 1, 0, resp, bid_o);
    check("strb_full_bresp", resp, OKAY);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    axi_write(4'd1, 32'h200, 8'd0, 3'd3, INCR, 1, 0, resp, bid_o);
    check("strb_part_bresp", resp, OKAY);
    erd[0] = 64'hFFFF_FFFF_0000_0000;
    axi_read(4'd1, 32'h200, 8'd0, 3'd3, INCR, OKAY, 4'b1111);

    // Early wlast on beat 1 of a 4-beat burst
    wd[0] = 64'hA0; wd[1] = 64'hA1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(4'd8, 32'h300, 8'd3, 3'd3, INCR, 2, 0, resp, bid_o);
    check("early_wlast_bresp", resp, SLVERR);
    check("early_wlast_bid", bid_o, 4'd8);
    check("early_wlast_idle", axi.awready, 1'b1);

    // Illegal burst type and oversize beat: writes suppressed
    wd[0] = 64'hDEAD; ws[0] = 8'hFF;
    axi_write(4'd3, 32'h100, 8'd0, 3'd3, 2'b11, 1, 0, resp, bid_o);
    check("rsvd_burst_bresp", resp, SLVERR);
    wd[0] = 64'hBEEF;
    axi_write(4'd3, 32'h108, 8'd0, 3'd4, INCR, 1, 0, resp, bid_o);
    check("oversize_bresp", resp, SLVERR);
    erd[0] = 64'h11; erd[1] = 64'h22;
    axi_read(4'd3, 32'h100, 8'd1, 3'd3, INCR, OKAY, 4'b1111);

    // Concurrent AW and AR accepted on the same edge
    check("cc_awready_pre", axi.awready, 1'b1);
    check("cc_arready_pre", axi.arready, 1'b1);
    axi.awid = 4'd3; axi.awaddr = 32'h400; axi.awlen = 8'd0; axi.awsize = 3'd3;
    axi.awburst = INCR; axi.awvalid = 1'b1;
    axi.arid = 4'd4; axi.araddr = 32'h100; axi.arlen = 8'd0; axi.arsize = 3'd3;
    axi.arburst = INCR; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.arvalid = 1'b0;
    check("cc_wready", axi.wready, 1'b1);
    check("cc_rvalid", axi.rvalid, 1'b1);
    check("cc_awready_low", axi.awready, 1'b0);
    check("cc_arready_low", axi.arready, 1'b0);
    check("cc_rdata", axi.rdata, 64'h11);
    check("cc_rlast", axi.rlast, 1'b1);
    axi.wdata = 64'hABCD; axi.wstrb = 8'hFF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
    axi.rready = 1'b1;
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.rready = 1'b0;
    check("cc_bvalid", axi.bvalid, 1'b1);
    check("cc_bresp", axi.bresp, OKAY);
    check("cc_bid", axi.bid, 4'd3);
    check("cc_rvalid_done", axi.rvalid, 1'b0);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    erd[0] = 64'hABCD;
    axi_read(4'd4, 32'h400, 8'd0, 3'd3, INCR, OKAY, 4'b1111);

    // Address beyond DEPTH words
`ifdef AXI_SLV_DECERR_EN
    erd[0] = 64'h0;
    axi_read(4'd5, 32'h8100, 8'd0, 3'd3, INCR, DECERR, 4'b1111);
`else
    erd[0] = 64'h11;
    axi_read(4'd5, 32'h8100, 8'd0, 3'd3, INCR, OKAY, 4'b1111);
`endif

    // Reset in the middle of a read burst
    axi.arid = 4'd2; axi.araddr = 32'h100; axi.arlen = 8'd3; axi.arsize = 3'd3;
    axi.arburst = INCR; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    check("mr_rvalid", axi.rvalid, 1'b1);
    check("mr_rdata0", axi.rdata, 64'h11);
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    check("mr_rdata1", axi.rdata, 64'h22);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("mr_rst_rvalid", axi.rvalid, 1'b0);
    check("mr_rst_arready", axi.arready, 1'b0);
    check("mr_rst_rdata", axi.rdata, 64'h0);
    tick();
    check("mr_rel_arready", axi.arready, 1'b1);
    check("mr_rel_awready", axi.awready, 1'b1);
    erd[0] = 64'h11; erd[1] = 64'h22; erd[2] = 64'h33; erd[3] = 64'h44;
    axi_read(4'd2, 32'h100, 8'd3, 3'd3, INCR, OKAY, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
